// File: rtl/reflector_program_if.sv
// Pair-load stream between a wiring source and the programmable reflector.
interface reflector_program_if;
  logic       pair_valid;
  logic [4:0] pair_a;
  logic [4:0] pair_b;
  logic       pair_ready;

  modport master (
    output pair_valid,
    output pair_a,
    output pair_b,
    input  pair_ready
  );

  modport slave (
    input  pair_valid,
    input  pair_a,
    input  pair_b,
    output pair_ready
  );
endinterface

// File: rtl/reflector_program.sv
// Programmable (UKW-D style) reflector: loads letter pairs into an involutive
// 26-entry wiring table, validating each pair, then serves registered lookups.
module reflector_program #(
  parameter int unsigned NUM_PAIRS = 13
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  reflector_program_if.slave         pair_bus,
  input  logic [4:0]                 code,
  output logic [4:0]                 val,
  output logic                       table_valid,
  output logic                       busy,
  output logic                       error,
  output logic [1:0]                 err_code
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [4:0] LAST_LETTER = 5'd25;
  localparam logic [3:0] LAST_PAIR   = 4'(NUM_PAIRS);

  state_t      state;
  state_t      state_next;

  logic [4:0]  tbl [26];
  logic [25:0] used;
  logic [3:0]  pair_cnt;

  logic        range_bad;
  logic        self_bad;
  logic        dup_bad;
  logic        clear;
  logic        clean;
  logic [1:0]  err_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next          = state;
    clear               = 1'b0;
    clean               = 1'b0;
    err_next            = 2'd0;
    pair_bus.pair_ready = 1'b0;
    busy                = 1'b0;
    table_valid         = 1'b0;

    range_bad = (pair_bus.pair_a > LAST_LETTER) || (pair_bus.pair_b > LAST_LETTER);
    self_bad  = (pair_bus.pair_a == pair_bus.pair_b);
    // used[] is only indexed once both letters are known to be in range
    dup_bad   = 1'b0;
    if (!range_bad) begin
      dup_bad = used[pair_bus.pair_a] || used[pair_bus.pair_b];
    end

    case (state)
      IDLE, ERROR: begin
        if (start) begin
          clear      = 1'b1;
          state_next = LOAD;
        end
      end
      DONE: begin
        table_valid = 1'b1;
        if (start) begin
          clear      = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        pair_bus.pair_ready = 1'b1;
        busy                = 1'b1;
        if (pair_bus.pair_valid) begin
          if (range_bad) begin
            err_next = 2'd1;
          end else if (self_bad) begin
            err_next = 2'd2;
          end else if (dup_bad) begin
            err_next = 2'd3;
          end

          if (err_next != 2'd0) begin
            state_next = ERROR;
          end else begin
            clean = 1'b1;
            if (pair_cnt + 4'd1 == LAST_PAIR) begin
              state_next = DONE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 26; i++) begin
        tbl[i] <= 5'(i);
      end
      used     <= '0;
      pair_cnt <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < 26; i++) begin
        tbl[i] <= 5'(i);
      end
      used     <= '0;
      pair_cnt <= '0;
    end else if (clean) begin
      tbl[pair_bus.pair_a]  <= pair_bus.pair_b;
      tbl[pair_bus.pair_b]  <= pair_bus.pair_a;
      used[pair_bus.pair_a] <= 1'b1;
      used[pair_bus.pair_b] <= 1'b1;
      pair_cnt              <= pair_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error    <= 1'b0;
      err_code <= '0;
    end else if (clear) begin
      error    <= 1'b0;
      err_code <= '0;
    end else if (err_next != 2'd0) begin
      error    <= 1'b1;
      err_code <= err_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val <= '0;
    end else if (state == DONE && code <= LAST_LETTER) begin
      val <= tbl[code];
    end else begin
      val <= '0;
    end
  end

endmodule

// File: tb/tb_reflector_program.sv
// Randomised self-checking bench for reflector_program against a pair-list
// reference model of the reflector wiring.
module tb_reflector_program;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start13 = 1'b0;
  logic       start2 = 1'b0;
  logic [4:0] code13 = '0;
  logic [4:0] code2 = '0;
  logic [4:0] val13, val2;
  logic       tv13, tv2, busy13, busy2, err13, err2;
  logic [1:0] ec13, ec2;

  reflector_program_if bus13 ();
  reflector_program_if bus2 ();

  reflector_program #(.NUM_PAIRS(13)) dut13 (
    .clk(clk), .reset(reset), .start(start13), .pair_bus(bus13),
    .code(code13), .val(val13), .table_valid(tv13), .busy(busy13),
    .error(err13), .err_code(ec13)
  );

  reflector_program #(.NUM_PAIRS(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .pair_bus(bus2),
    .code(code2), .val(val2), .table_valid(tv2), .busy(busy2),
    .error(err2), .err_code(ec2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the wiring as a list of pairs applied to an identity table.
  int qa [13];
  int qb [13];
  int ref_tbl [26];
  bit ref_valid;

  function automatic void ref_build(input int n);
    for (int i = 0; i < 26; i++) ref_tbl[i] = i;
    for (int k = 0; k < n; k++) begin
      ref_tbl[qa[k]] = qb[k];
      ref_tbl[qb[k]] = qa[k];
    end
  endfunction

  function automatic int ref_lookup(input int c);
    if (ref_valid && c <= 25) return ref_tbl[c];
    return 0;
  endfunction

  function automatic void random_pairing();
    int perm [26];
    int j, t;
    for (int i = 0; i < 26; i++) perm[i] = i;
    for (int i = 25; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int k = 0; k < 13; k++) begin
      qa[k] = perm[2*k];
      qb[k] = perm[2*k+1];
    end
  endfunction

  task automatic set_pairs(input int a [13], input int b [13]);
    for (int k = 0; k < 13; k++) begin
      qa[k] = a[k];
      qb[k] = b[k];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start13();
    start13 = 1'b1;
    tick();
    start13 = 1'b0;
  endtask

  // Offers the first n pairs of qa/qb to dut13; counts cycles with busy or ready low.
  task automatic do_load(input int n, input bit gaps, output int drops);
    drops = 0;
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          bus13.pair_valid = 1'b0;
          tick();
          if (!busy13) drops++;
        end
      end
      if (!bus13.pair_ready || !busy13) drops++;
      bus13.pair_valid = 1'b1;
      bus13.pair_a     = 5'(qa[k]);
      bus13.pair_b     = 5'(qb[k]);
      tick();
    end
    bus13.pair_valid = 1'b0;
  endtask

  task automatic send13(input int a, input int b);
    bus13.pair_valid = 1'b1;
    bus13.pair_a     = 5'(a);
    bus13.pair_b     = 5'(b);
    tick();
    bus13.pair_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus13.pair_ready, busy13, tv13, err13, ec13, val13} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0", {bus13.pair_ready, busy13, tv13, err13, ec13, val13});
    end
    reset = 1'b0;
    code13 = 5'd3;
    tick();
    tick();
    checks++;
    if (val13 !== 5'd0 || bus13.pair_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_lookup: val=%0d ready=%b expected 0 0", val13, bus13.pair_ready);
    end
  endtask

  task automatic test_reflector_b();
    int a [13] = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 10, 12, 19, 21};
    int b [13] = '{24, 17, 20, 7, 16, 18, 11, 15, 23, 13, 14, 25, 22};
    int codes [4] = '{0, 19, 24, 26};
    int drops;
    set_pairs(a, b);
    ref_valid = 1'b0;
    pulse_start13();
    checks++;
    if (bus13.pair_ready !== 1'b1 || tv13 !== 1'b0) begin
      errors++;
      $display("FAIL b_ready_after_start: ready=%b tv=%b expected 1 0", bus13.pair_ready, tv13);
    end
    do_load(12, 1'b0, drops);
    checks++;
    if (tv13 !== 1'b0 || bus13.pair_ready !== 1'b1) begin
      errors++;
      $display("FAIL b_before_last: tv=%b ready=%b expected 0 1", tv13, bus13.pair_ready);
    end
    send13(qa[12], qb[12]);
    ref_build(13);
    ref_valid = 1'b1;
    checks++;
    if (tv13 !== 1'b1 || bus13.pair_ready !== 1'b0 || busy13 !== 1'b0 || drops != 0) begin
      errors++;
      $display("FAIL b_done: tv=%b ready=%b busy=%b drops=%0d expected 1 0 0 0", tv13, bus13.pair_ready, busy13, drops);
    end
    // a pair offered while DONE must not be accepted
    send13(0, 1);
    foreach (codes[i]) begin
      code13 = 5'(codes[i]);
      tick();
      checks++;
      if (int'(val13) != ref_lookup(codes[i])) begin
        errors++;
        $display("FAIL b_lookup code=%0d: got %0d expected %0d", codes[i], val13, ref_lookup(codes[i]));
      end
    end
  endtask

  task automatic test_reflector_c_gaps();
    int a [13] = '{0, 1, 2, 3, 4, 6, 7, 10, 11, 12, 13, 16, 18};
    int b [13] = '{5, 21, 15, 9, 8, 14, 24, 17, 25, 23, 22, 19, 20};
    int codes [3] = '{0, 7, 25};
    int drops;
    set_pairs(a, b);
    ref_valid = 1'b0;
    pulse_start13();
    do_load(13, 1'b1, drops);
    ref_build(13);
    ref_valid = 1'b1;
    checks++;
    if (drops != 0 || tv13 !== 1'b1) begin
      errors++;
      $display("FAIL c_busy_through_load: drops=%0d tv=%b expected 0 1", drops, tv13);
    end
    foreach (codes[i]) begin
      code13 = 5'(codes[i]);
      tick();
      checks++;
      if (int'(val13) != ref_lookup(codes[i])) begin
        errors++;
        $display("FAIL c_lookup code=%0d: got %0d expected %0d", codes[i], val13, ref_lookup(codes[i]));
      end
    end
  endtask

  task automatic test_errors();
    ref_valid = 1'b0;
    pulse_start13();
    send13(0, 24);
    send13(24, 3);
    checks++;
    if (err13 !== 1'b1 || ec13 !== 2'd3 || bus13.pair_ready !== 1'b0 || tv13 !== 1'b0) begin
      errors++;
      $display("FAIL err_dup: error=%b code=%0d ready=%b tv=%b expected 1 3 0 0", err13, ec13, bus13.pair_ready, tv13);
    end
    checks++;
    if (dut13.tbl[3] !== 5'd3 || dut13.tbl[24] !== 5'd0) begin
      errors++;
      $display("FAIL err_partial_table: t3=%0d t24=%0d expected 3 0", dut13.tbl[3], dut13.tbl[24]);
    end
    code13 = 5'd0;
    tick();
    checks++;
    if (val13 !== 5'd0) begin
      errors++;
      $display("FAIL err_lookup_invalid: got %0d expected 0", val13);
    end
    // start together with a pair: the pair must be dropped
    start13 = 1'b1;
    bus13.pair_valid = 1'b1;
    bus13.pair_a = 5'd7;
    bus13.pair_b = 5'd8;
    tick();
    start13 = 1'b0;
    bus13.pair_valid = 1'b0;
    checks++;
    if (err13 !== 1'b0 || ec13 !== 2'd0 || dut13.tbl[7] !== 5'd7 || dut13.tbl[0] !== 5'd0) begin
      errors++;
      $display("FAIL err_start_clears: error=%b code=%0d t7=%0d t0=%0d expected 0 0 7 0", err13, ec13, dut13.tbl[7], dut13.tbl[0]);
    end
    send13(5, 5);
    checks++;
    if (err13 !== 1'b1 || ec13 !== 2'd2) begin
      errors++;
      $display("FAIL err_self: error=%b code=%0d expected 1 2", err13, ec13);
    end
    pulse_start13();
    send13(26, 1);
    checks++;
    if (err13 !== 1'b1 || ec13 !== 2'd1) begin
      errors++;
      $display("FAIL err_range: error=%b code=%0d expected 1 1", err13, ec13);
    end
    // range outranks self-pair
    pulse_start13();
    send13(31, 31);
    checks++;
    if (ec13 !== 2'd1) begin
      errors++;
      $display("FAIL err_priority: code=%0d expected 1", ec13);
    end
    // letter 25 is legal; reusing it is a duplicate
    pulse_start13();
    send13(25, 0);
    checks++;
    if (err13 !== 1'b0 || busy13 !== 1'b1) begin
      errors++;
      $display("FAIL err_z_legal: error=%b busy=%b expected 0 1", err13, busy13);
    end
    send13(1, 25);
    checks++;
    if (ec13 !== 2'd3) begin
      errors++;
      $display("FAIL err_dup_z: code=%0d expected 3", ec13);
    end
  endtask

  task automatic test_partial_restart();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    bus2.pair_valid = 1'b1;
    bus2.pair_a = 5'd0; bus2.pair_b = 5'd1;
    tick();
    bus2.pair_a = 5'd2; bus2.pair_b = 5'd3;
    tick();
    bus2.pair_valid = 1'b0;
    checks++;
    if (tv2 !== 1'b1 || bus2.pair_ready !== 1'b0) begin
      errors++;
      $display("FAIL p2_done: tv=%b ready=%b expected 1 0", tv2, bus2.pair_ready);
    end
    code2 = 5'd4;
    tick();
    checks++;
    if (val2 !== 5'd4) begin
      errors++;
      $display("FAIL p2_lookup4: got %0d expected 4", val2);
    end
    code2 = 5'd1;
    tick();
    checks++;
    if (val2 !== 5'd0) begin
      errors++;
      $display("FAIL p2_lookup1: got %0d expected 0", val2);
    end
    code2 = 5'd3;
    tick();
    checks++;
    if (val2 !== 5'd2) begin
      errors++;
      $display("FAIL p2_lookup3: got %0d expected 2", val2);
    end
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    checks++;
    if (tv2 !== 1'b0 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL p2_restart_tv: tv=%b busy=%b expected 0 1", tv2, busy2);
    end
    tick();
    checks++;
    if (val2 !== 5'd0) begin
      errors++;
      $display("FAIL p2_restart_val: got %0d expected 0", val2);
    end
    for (int i = 0; i < 26; i++) begin
      checks++;
      if (int'(dut2.tbl[i]) != i) begin
        errors++;
        $display("FAIL p2_identity[%0d]: got %0d expected %0d", i, dut2.tbl[i], i);
      end
    end
    // same letters, new partners: stale used bits would flag a duplicate
    bus2.pair_valid = 1'b1;
    bus2.pair_a = 5'd1; bus2.pair_b = 5'd2;
    tick();
    bus2.pair_a = 5'd0; bus2.pair_b = 5'd3;
    tick();
    bus2.pair_valid = 1'b0;
    code2 = 5'd3;
    tick();
    checks++;
    if (tv2 !== 1'b1 || err2 !== 1'b0 || val2 !== 5'd0) begin
      errors++;
      $display("FAIL p2_reload: tv=%b error=%b val=%0d expected 1 0 0", tv2, err2, val2);
    end
  endtask

  task automatic test_reset_midload();
    int drops;
    random_pairing();
    ref_valid = 1'b0;
    pulse_start13();
    do_load(6, 1'b0, drops);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus13.pair_ready, busy13, tv13, err13, ec13, val13} !== 10'd0 || dut13.used !== 26'd0) begin
      errors++;
      $display("FAIL reset_midload: outs=%b used=%h expected 0 0", {bus13.pair_ready, busy13, tv13, err13, ec13, val13}, dut13.used);
    end
    #2;
    reset = 1'b0;
    tick();
    random_pairing();
    pulse_start13();
    do_load(13, 1'b0, drops);
    ref_build(13);
    ref_valid = 1'b1;
    checks++;
    if (tv13 !== 1'b1 || err13 !== 1'b0) begin
      errors++;
      $display("FAIL reset_reload: tv=%b error=%b expected 1 0", tv13, err13);
    end
    for (int c = 0; c < 32; c++) begin
      code13 = 5'(c);
      tick();
      checks++;
      if (int'(val13) != ref_lookup(c)) begin
        errors++;
        $display("FAIL reset_reload_lookup code=%0d: got %0d expected %0d", c, val13, ref_lookup(c));
      end
    end
  endtask

  task automatic test_random_loads();
    int drops;
    int c;
    for (int r = 0; r < 4; r++) begin
      random_pairing();
      ref_valid = 1'b0;
      pulse_start13();
      do_load(13, 1'b1, drops);
      ref_build(13);
      ref_valid = 1'b1;
      checks++;
      if (tv13 !== 1'b1 || drops != 0) begin
        errors++;
        $display("FAIL rand_done round=%0d: tv=%b drops=%0d expected 1 0", r, tv13, drops);
      end
      for (int n = 0; n < 20; n++) begin
        c = int'($urandom_range(0, 31));
        code13 = 5'(c);
        tick();
        checks++;
        if (int'(val13) != ref_lookup(c)) begin
          errors++;
          $display("FAIL rand_lookup round=%0d code=%0d: got %0d expected %0d", r, c, val13, ref_lookup(c));
        end
      end
    end
  endtask

  initial begin
    bus13.pair_valid = 1'b0;
    bus13.pair_a = '0;
    bus13.pair_b = '0;
    bus2.pair_valid = 1'b0;
    bus2.pair_a = '0;
    bus2.pair_b = '0;
    ref_valid = 1'b0;
    #3;
    test_reset();
    test_reflector_b();
    test_reflector_c_gaps();
    test_errors();
    test_partial_restart();
    test_reset_midload();
    test_random_loads();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reflector_program.md
# reflector_program

Programmable Enigma reflector (UKW-D style) that writes the wiring table which the fixed B/C reflector lookups hardcode. It takes letter pairs over a valid/ready stream, checks each pair, builds a 26-entry involutive table and then serves registered lookups on the same `code`/`val` 5-bit letter indices (A=0 … Z=25). It sits beside the fixed reflectors, ahead of the reflector-select mux in the rotor datapath.

## Interface
- `NUM_PAIRS`, default 13, is the number of pairs per load, legal range 1..13. Letters left unpaired map to themselves.
- `clk`  in  1  is the single clock. All state updates on the rising edge.
- `reset`  in  1  is the reset: asynchronous, active-high.
- `start`  in  1  is a one-cycle pulse that begins a new load.
- `pair_valid`  in  1  means a pair is offered this cycle.
- `pair_a`  in  5  is the first letter of the pair.
- `pair_b`  in  5  is the second letter of the pair.
- `pair_ready`  out  1  is high while the block accepts pairs.
- `code`  in  5  is the lookup letter index.
- `val`  out  5  is the reflected letter index, registered.
- `table_valid`  out  1  means the table is complete and lookups are valid.
- `busy`  out  1  is high while in LOAD.
- `error`  out  1  is a sticky load error, cleared by `start` or `reset`.
- `err_code`  out  2  encodes the error: 0 none, 1 range, 2 self-pair, 3 duplicate.

## Operation
- State machine states are IDLE, LOAD, DONE and ERROR.
- Storage:
  - `table[0..25]`, 5 bits each.
  - `used[25:0]`.
  - `pair_cnt`, 4 bits.
- `start` in IDLE, DONE or ERROR:
  - Table goes to identity (`table[i]=i`), `used=0`, `pair_cnt=0`.
  - `error=0`, `err_code=0`, `table_valid=0`.
  - Next state is LOAD.
- `start` in LOAD is ignored.
- LOAD:
  - `pair_ready=1` and `busy=1`.
  - A handshake is `pair_valid && pair_ready`.
  - Each handshake is checked in priority order:
    - Range: `pair_a>25` or `pair_b>25` gives err 1.
    - Self-pair: `pair_a==pair_b` gives err 2.
    - Duplicate: `used[pair_a]` or `used[pair_b]` gives err 3.
  - On a clean pair:
    - `table[a]=b`, `table[b]=a`, set `used[a]` and `used[b]`, `pair_cnt+1`.
    - If the new count equals `NUM_PAIRS`, next state is DONE; otherwise stay in LOAD.
  - On an error, the offending pair is not written, `error=1`, `err_code` is latched, and next state is ERROR.
- DONE: `table_valid=1`, `pair_ready=0`, `busy=0`.
- ERROR:
  - `pair_ready=0`, `table_valid=0`.
  - Partial table contents are retained but are not valid.
- Lookup runs every cycle:
  - If `table_valid` and `code<=25`, `val <= table[code]`; otherwise `val <= 0`.
  - In DONE the table is an involution: `table[table[x]]==x`.

## Timing
- Reset values:
  - State IDLE.
  - `pair_ready=0`, `busy=0`, `table_valid=0`, `error=0`, `err_code=0`, `val=0`.
  - Table identity, `used=0`, `pair_cnt=0`.
- `start` sampled at edge T puts the block in LOAD from T; `pair_ready=1` in the cycle after T.
- One pair may be accepted per cycle. `pair_valid` gaps stall the load with no state change.
- Last pair accepted at edge T sets `table_valid=1` and `pair_ready=0` after T, so no further pair is accepted.
- Minimum load time is `NUM_PAIRS` cycles after LOAD entry.
- A bad pair at edge T sets `error` and `err_code` after T; `pair_ready` drops in the same cycle.
- Lookup latency is 1 cycle: `code` at edge T gives `val` after T.
- `val` is forced to 0 in the cycle after `table_valid` drops following a `start` from DONE.
- `pair_valid` and `start` together in IDLE, DONE or ERROR: the pair is not accepted, because `pair_ready=0`.
- `reset` mid-LOAD immediately returns every output and all storage to reset values.

## Test plan
- Reflector B:
  - Stimulus: load the 13 pairs (0,24) (1,17) (2,20) (3,7) (4,16) (5,18) (6,11) (8,15) (9,23) (10,13) (12,14) (19,25) (21,22) back-to-back.
  - Response: `table_valid` high 1 cycle after the 13th handshake.
  - Lookups: `code` 0→24, 19→25, 24→0, 26→0, each 1 cycle later.
- Reflector C with random `pair_valid` gaps:
  - Stimulus: load (0,5) (1,21) (2,15) (3,9) (4,8) (6,14) (7,24) (10,17) (11,25) (12,23) (13,22) (16,19) (18,20) with gaps.
  - Response: `code` 0→5, 7→24, 25→11.
  - Check: `busy` stays high throughout the load.
- Errors:
  - Pair (0,24) then (24,3) gives `error=1`, `err_code=3`; `table[3]` stays 3.
  - A fresh load with (5,5) gives `err_code=2`.
  - A fresh load with (26,1) gives `err_code=1`.
- Partial load and restart:
  - `NUM_PAIRS=2`, pairs (0,1) (2,3): `code` 4→4, 1→0.
  - `start` from DONE: `table_valid` drops, `val=0`, table returns to identity.
- Reset mid-load:
  - Stimulus: assert `reset` after 6 pairs.
  - Response: all outputs return to 0 asynchronously.
  - Check: a new `start` plus a full load works and no stale `used` bits remain.
